// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding (common with the receive side),
// parity selectors and line-level bit constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    START  = 3'b001,
    DATA   = 3'b010,
    PARITY = 3'b011,
    STOP   = 3'b100
  } tx_state_t;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Data shift register and bit counter for the UART transmitter; load/shift
// are driven by the FSM, done flags the last data bit of the frame.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic                  shift_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  next_bit_o,
  output logic                  done_o
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;

  assign done_o = (bit_cnt_q == BW'(DATA_WIDTH - 1));
  // Next-cycle LSB lets the FSM register TX_OUT without an extra stage.
  assign next_bit_o = shreg_d[0];

  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    if (load_i) begin
      shreg_d   = data_i;
      bit_cnt_d = {BW{1'b0}};
    end else if (shift_i) begin
      shreg_d   = {1'b0, shreg_q[DATA_WIDTH-1:1]};
      bit_cnt_d = done_o ? {BW{1'b0}} : bit_cnt_q + BW'(1);
    end else begin
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shreg_q   <= {DATA_WIDTH{1'b0}};
      bit_cnt_q <= {BW{1'b0}};
    end else begin
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_fsm.sv
// UART transmitter: start, DATA_WIDTH data bits LSB first, optional parity, stop;
// each bit lasts PRESCALE clocks. Define UART_TX_TWO_STOP_EN for two stop bits.
module uart_tx_fsm
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int             CW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(PRESCALE - 1);

  tx_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          par_en_q, par_en_d;
  logic          parity_q, parity_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          load_s, shift_s, next_bit_s, done_s, bit_end_s;
`ifdef UART_TX_TWO_STOP_EN
  logic          stop_cnt_q, stop_cnt_d;
`endif

  assign bit_end_s = (cnt_q == CNT_LAST);
  assign TX_OUT    = tx_q;
  assign busy      = busy_q;

  uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
    .clk_i      (clk),
    .rst_ni     (rst),
    .load_i     (load_s),
    .shift_i    (shift_s),
    .data_i     (P_DATA),
    .next_bit_o (next_bit_s),
    .done_o     (done_s)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = bit_end_s ? {CW{1'b0}} : cnt_q + CW'(1);
    par_en_d = par_en_q;
    parity_d = parity_q;
    load_s   = 1'b0;
    shift_s  = 1'b0;
    tx_d     = STOP_BIT;
    busy_d   = 1'b0;
`ifdef UART_TX_TWO_STOP_EN
    stop_cnt_d = stop_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = {CW{1'b0}};
        if (DATA_VALID) begin
          load_s   = 1'b1;
          par_en_d = PAR_EN;
          parity_d = (^P_DATA) ^ (PAR_TYP == PAR_ODD);
          state_d  = START;
        end else begin
          state_d  = IDLE;
        end
      end
      START:  if (bit_end_s) state_d = DATA; else state_d = START;
      DATA: begin
        if (bit_end_s) begin
          shift_s = 1'b1;
          if (done_s) state_d = par_en_q ? PARITY : STOP;
          else        state_d = DATA;
        end else begin
          state_d = DATA;
        end
      end
      PARITY: if (bit_end_s) state_d = STOP; else state_d = PARITY;
      STOP: begin
`ifdef UART_TX_TWO_STOP_EN
        // The stop-bit counter holds the state in STOP for a second bit time.
        if (bit_end_s && stop_cnt_q) begin
          state_d    = IDLE;
          stop_cnt_d = 1'b0;
        end else if (bit_end_s) begin
          stop_cnt_d = 1'b1;
        end else begin
          stop_cnt_d = stop_cnt_q;
        end
`else
        if (bit_end_s) state_d = IDLE; else state_d = STOP;
`endif
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CW{1'b0}};
      end
    endcase

    // Outputs follow the next state so TX_OUT/busy come straight from flops.
    case (state_d)
      START:   begin tx_d = START_BIT;  busy_d = 1'b1; end
      DATA:    begin tx_d = next_bit_s; busy_d = 1'b1; end
      PARITY:  begin tx_d = parity_d;   busy_d = 1'b1; end
      STOP:    begin tx_d = STOP_BIT;   busy_d = 1'b1; end
      default: begin tx_d = STOP_BIT;   busy_d = 1'b0; end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= {CW{1'b0}};
      par_en_q   <= 1'b0;
      parity_q   <= 1'b0;
      tx_q       <= STOP_BIT;
      busy_q     <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      stop_cnt_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      par_en_q   <= par_en_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
`ifdef UART_TX_TWO_STOP_EN
      stop_cnt_q <= stop_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Self-checking bench for uart_tx_fsm: two instances (PRESCALE 4 and 1) against a
// frame-level reference model, plus directed frames with literal expectations.
module tb_uart_tx_fsm;

  localparam int P0 = 4;
  localparam int P1 = 1;
  localparam int W  = 8;
`ifdef UART_TX_TWO_STOP_EN
  localparam int NSTOP = 2;
  localparam int T1_BITS = 32'hD4A, T1_CYC = 48, T2O_BITS = 32'hF4A;
  localparam int T2N_BITS = 32'h74A, T2N_CYC = 44, T3A_BITS = 32'h678, T3A_CYC = 44;
  localparam int T3B_BITS = 32'h7FE, T4_BITS = 32'hE02, T5_BITS = 32'hC00, T5_CYC = 12;
`else
  localparam int NSTOP = 1;
  localparam int T1_BITS = 32'h54A, T1_CYC = 44, T2O_BITS = 32'h74A;
  localparam int T2N_BITS = 32'h34A, T2N_CYC = 40, T3A_BITS = 32'h278, T3A_CYC = 40;
  localparam int T3B_BITS = 32'h3FE, T4_BITS = 32'h602, T5_BITS = 32'h400, T5_CYC = 11;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] P_DATA = 8'h00;
  logic       DATA_VALID = 1'b0, PAR_EN = 1'b0, PAR_TYP = 1'b0;
  logic       tx0, busy0, tx1, busy1;

  int vectors = 0;
  int miscompares = 0;

  // Frame model per instance: bit list of the frame and current cycle (-1 = idle).
  logic fb [2][12];
  int   nb [2]  = '{0, 0};
  int   pos [2] = '{-1, -1};

  always #5 clk = ~clk;

  uart_tx_fsm #(.DATA_WIDTH(W), .PRESCALE(P0)) dut0 (
    .clk(clk), .rst(rst), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .TX_OUT(tx0), .busy(busy0));

  uart_tx_fsm #(.DATA_WIDTH(W), .PRESCALE(P1)) dut1 (
    .clk(clk), .rst(rst), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .TX_OUT(tx1), .busy(busy1));

  function automatic int pres(input int d);
    return (d == 0) ? P0 : P1;
  endfunction

  function automatic int get_tx(input int d);
    return (d == 0) ? int'(tx0) : int'(tx1);
  endfunction

  function automatic int get_busy(input int d);
    return (d == 0) ? int'(busy0) : int'(busy1);
  endfunction

  function automatic int exp_tx(input int d);
    return (pos[d] < 0) ? 1 : int'(fb[d][pos[d] / pres(d)]);
  endfunction

  function automatic int exp_busy(input int d);
    return (pos[d] < 0) ? 0 : 1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  task automatic model_step();
    int n;
    for (int d = 0; d < 2; d++) begin
      if (!rst) begin
        pos[d] = -1;
      end else if (pos[d] >= 0) begin
        pos[d]++;
        if (pos[d] == nb[d] * pres(d)) pos[d] = -1;
      end else if (DATA_VALID) begin
        fb[d][0] = 1'b0;
        for (int i = 0; i < W; i++) fb[d][1 + i] = P_DATA[i];
        n = W + 1;
        if (PAR_EN) begin
          fb[d][n] = (^P_DATA) ^ PAR_TYP;
          n++;
        end
        for (int s = 0; s < NSTOP; s++) begin
          fb[d][n] = 1'b1;
          n++;
        end
        nb[d]  = n;
        pos[d] = 0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("dut%0d_tx", d), get_tx(d), exp_tx(d));
        check($sformatf("dut%0d_busy", d), get_busy(d), exp_busy(d));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((busy0 || busy1) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait_bound", int'(n < 500), 1);
  endtask

  task automatic send(input logic [7:0] d, input logic pe, input logic pt);
    wait_idle();
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; DATA_VALID = 1'b1;
    @(negedge clk);
    DATA_VALID = 1'b0;
  endtask

  // Called at the negedge after acceptance; samples each bit mid-way and counts busy cycles.
  task automatic capture(input int d, output int bits, output int cycles);
    bits = 0;
    cycles = 0;
    while (get_busy(d) != 0 && cycles < 200) begin
      if (cycles % pres(d) == pres(d) / 2)
        bits = bits | (get_tx(d) << (cycles / pres(d)));
      cycles++;
      @(negedge clk);
    end
  endtask

  initial begin
    int b, c;
    repeat (3) @(negedge clk);
    check("rst_tx0", int'(tx0), 1);
    check("rst_busy0", int'(busy0), 0);
    check("rst_tx1", int'(tx1), 1);
    check("rst_busy1", int'(busy1), 0);
    rst = 1'b1;
    @(negedge clk);

    send(8'hA5, 1'b1, 1'b0);
    capture(0, b, c);
    check("t1_even_bits", b, T1_BITS);
    check("t1_even_busy", c, T1_CYC);

    send(8'hA5, 1'b1, 1'b1);
    capture(0, b, c);
    check("t2_odd_bits", b, T2O_BITS);
    check("t2_odd_busy", c, T1_CYC);

    send(8'hA5, 1'b0, 1'b0);
    capture(0, b, c);
    check("t2_nopar_bits", b, T2N_BITS);
    check("t2_nopar_busy", c, T2N_CYC);

    wait_idle();
    P_DATA = 8'h3C; PAR_EN = 1'b0; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
    @(negedge clk);
    P_DATA = 8'hFF;
    capture(0, b, c);
    check("t3_first_bits", b, T3A_BITS);
    check("t3_first_busy", c, T3A_CYC);
    check("t3_idle_gap_tx", int'(tx0), 1);
    @(negedge clk);
    check("t3_restart_busy", int'(busy0), 1);
    DATA_VALID = 1'b0;
    capture(0, b, c);
    check("t3_second_bits", b, T3B_BITS);

    send(8'hB6, 1'b1, 1'b0);
    repeat (17) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("t4_async_tx0", int'(tx0), 1);
    check("t4_async_busy0", int'(busy0), 0);
    check("t4_async_tx1", int'(tx1), 1);
    @(negedge clk);
    check("t4_held_busy0", int'(busy0), 0);
    #2 rst = 1'b1;
    @(negedge clk);
    send(8'h01, 1'b1, 1'b0);
    capture(0, b, c);
    check("t4_clean_bits", b, T4_BITS);
    check("t4_clean_busy", c, T1_CYC);

    send(8'h00, 1'b1, 1'b0);
    capture(1, b, c);
    check("t5_p1_bits", b, T5_BITS);
    check("t5_p1_busy", c, T5_CYC);

    repeat (3000) begin
      @(negedge clk);
      DATA_VALID = ($urandom_range(0, 3) == 0);
      P_DATA     = 8'($urandom);
      PAR_EN     = 1'($urandom);
      PAR_TYP    = 1'($urandom);
    end
    DATA_VALID = 1'b0;
    wait_idle();
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
